// File: rtl/slowmem_arbiter_if.sv
// Bundles the two requester ports and the slowmem bus of slowmem_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// environment: the requesters plus the slowmem device.
interface slowmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // Requester side
    logic [1:0]    req;
    logic [1:0]    req_rnotw;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    ack;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    // Slowmem side
    logic          mem_strobe;
    logic          mem_rnotw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_mfc;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  req, req_rnotw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_mfc, mem_rdata,
        output ack, rsp_rdata, rsp_err, busy,
        output mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );

    modport slave (
        output req, req_rnotw, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_mfc, mem_rdata,
        input  ack, rsp_rdata, rsp_err, busy,
        input  mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/slowmem_arbiter.sv
// Two-port round-robin initiator for the shared slowmem.
// There is one outstanding transaction at a time. A transaction moves through
// IDLE -> STROBE -> (WAIT) -> ACK -> IDLE.
// Reads that never receive mem_mfc are aborted after TIMEOUT cycles in WAIT.
// An aborted read returns ERRDATA with rsp_err set.
// All outputs come straight from registers.
module slowmem_arbiter #(
    parameter int            AW      = 16,
    parameter int            DW      = 16,
    parameter int            TIMEOUT = 15,       // legal range 1..255
    parameter logic [DW-1:0] ERRDATA = 16'hFFFF
) (
    input logic               clk,
    input logic               reset,
    slowmem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    // Registered state and outputs (_q) with their next values (_d)
    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          busy_q, busy_d;
    logic          mem_strobe_q, mem_strobe_d;
    logic          mem_rnotw_q, mem_rnotw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Port picked by the round-robin rule when IDLE sees at least one request
    logic sel;

    // Round-robin pick: a tie goes to the port that was not granted last
    always_comb begin
        if (bus.req == 2'b11) begin
            sel = ~last_grant_q;
        end else begin
            sel = bus.req[1];
        end
    end

    // State register and registered outputs; reset aborts any operation in flight
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_strobe_q <= 1'b0;
            mem_rnotw_q  <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            mem_strobe_q <= mem_strobe_d;
            mem_rnotw_q  <= mem_rnotw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state and next-output logic of the transaction FSM
    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        mem_strobe_d = 1'b0;
        mem_rnotw_d  = mem_rnotw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                if (|bus.req) begin
                    // Latch the winner's fields. They stay on the bus until IDLE comes back.
                    grant_d      = sel;
                    last_grant_d = sel;
                    mem_rnotw_d  = bus.req_rnotw[sel];
                    mem_addr_d   = sel ? bus.req_addr1 : bus.req_addr0;
                    mem_wdata_d  = sel ? bus.req_wdata1 : bus.req_wdata0;
                    mem_strobe_d = 1'b1;
                    state_d      = STROBE;
                end
            end

            STROBE: begin
                if (mem_rnotw_q) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    // Slowmem commits the write on the edge that leaves STROBE
                    ack_d       = grant_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ACK;
                end
            end

            WAIT: begin
                if (bus.mem_mfc) begin
                    // mfc takes priority over a timeout on the same cycle
                    ack_d       = grant_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = bus.mem_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ACK;
                end else if (cnt_q == LAST_WAIT) begin
                    ack_d       = grant_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = ERRDATA;
                    rsp_err_d   = 1'b1;
                    state_d     = ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ACK: begin
                // Always pass through IDLE. A req still held during ACK is therefore not re-granted.
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ack        = ack_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;
    assign bus.mem_strobe = mem_strobe_q;
    assign bus.mem_rnotw  = mem_rnotw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_slowmem_arbiter.sv
// Scoreboard bench for slowmem_arbiter.
// The stimulus pushes the expected strobe and ack of every transaction into queues.
// Independent monitors pop those queues and compare whenever the DUT strobes or acks.
// A slowmem model with MEMDELAY=4 answers reads and commits writes.
module tb_slowmem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int TIMEOUT  = 15;
    localparam int MEMDELAY = 4;

    typedef struct {
        int            port;
        logic          rnotw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    slowmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    slowmem_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERRDATA(16'hFFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    txn_t strobe_q[$];
    txn_t ack_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slowmem model ----------------
    logic [DW-1:0] pre_mem [0:65535];   // preloaded contents
    logic [DW-1:0] wr_mem  [0:65535];   // contents written through the bus
    bit            wr_vld  [0:65535];
    logic          model_mfc   = 1'b0;
    logic [DW-1:0] model_rdata = '0;
    int            pend        = 0;
    logic [AW-1:0] pend_addr   = '0;
    bit            no_mfc      = 1'b0;
    logic          mfc_force   = 1'b0;

    assign bus.mem_mfc   = model_mfc | mfc_force;
    assign bus.mem_rdata = model_rdata;

    always @(posedge clk) begin
        model_mfc <= 1'b0;
        if (bus.mem_strobe) begin
            if (bus.mem_rnotw) begin
                pend      <= MEMDELAY;
                pend_addr <= bus.mem_addr;
            end else begin
                wr_mem[bus.mem_addr] <= bus.mem_wdata;
                wr_vld[bus.mem_addr] <= 1'b1;
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1 && !no_mfc) begin
                model_mfc   <= 1'b1;
                model_rdata <= wr_vld[pend_addr] ? wr_mem[pend_addr] : pre_mem[pend_addr];
            end
        end
    end

    // ---------------- strobe monitor ----------------
    initial begin : strobe_mon
        int   len;
        txn_t t;
        len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                len = 0;
            end else if (bus.mem_strobe) begin
                len++;
                if (len == 1) begin
                    if (strobe_q.size() == 0) begin
                        check("unexpected_strobe", 32'(bus.mem_strobe), 32'd0);
                    end else begin
                        t = strobe_q.pop_front();
                        check("strobe_addr", 32'(bus.mem_addr), 32'(t.addr));
                        check("strobe_rnotw", 32'(bus.mem_rnotw), 32'(t.rnotw));
                        if (!t.rnotw) check("strobe_wdata", 32'(bus.mem_wdata), 32'(t.wdata));
                    end
                end
            end else if (len != 0) begin
                check("strobe_width", 32'(len), 32'd1);
                len = 0;
            end
        end
    end

    // ---------------- ack / response monitor ----------------
    initial begin : ack_mon
        bit   prev_ack;
        txn_t t;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) check("busy_after_ack", 32'(bus.busy), 32'd0);
                if (bus.ack != 2'b00) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", 32'(bus.ack), 32'd0);
                    end else begin
                        t = ack_q.pop_front();
                        check("ack_port", 32'(bus.ack), (t.port == 1) ? 32'd2 : 32'd1);
                        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(t.rdata));
                        check("rsp_err", 32'(bus.rsp_err), 32'(t.err));
                    end
                    prev_ack = 1'b1;
                end else begin
                    prev_ack = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_txn(input int port, input logic rnotw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input logic err, input bit with_ack);
        txn_t t;
        t.port = port; t.rnotw = rnotw; t.addr = addr;
        t.wdata = wdata; t.rdata = rdata; t.err = err;
        strobe_q.push_back(t);
        if (with_ack) ack_q.push_back(t);
    endtask

    task automatic set_port(input int port, input logic rnotw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        bus.req_rnotw[port] = rnotw;
        if (port == 0) begin
            bus.req_addr0 = addr; bus.req_wdata0 = wdata;
        end else begin
            bus.req_addr1 = addr; bus.req_wdata1 = wdata;
        end
    endtask

    // Single transaction; latency counts posedges from the sampling edge up to the ack.
    task automatic do_txn(input string name, input int port, input logic rnotw,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        expect_txn(port, rnotw, addr, wdata, exp_rdata, exp_err, 1'b1);
        set_port(port, rnotw, addr, wdata);
        bus.req[port] = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.ack[port]) got = 1'b1;
        end
        bus.req[port] = 1'b0;
        check({name, "_done"}, 32'(got), 32'd1);
        if (got) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ack"}, 32'(bus.ack), 32'd0);
        check({name, "_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        check({name, "_err"}, 32'(bus.rsp_err), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_strobe"}, 32'(bus.mem_strobe), 32'd0);
        check({name, "_rnotw"}, 32'(bus.mem_rnotw), 32'd1);
        check({name, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({name, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Global watchdog in case a wait outside the bounded loops stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int  n, rem0, rem1, seen;
        bus.req        = 2'b00;
        bus.req_rnotw  = 2'b11;
        bus.req_addr0  = '0;
        bus.req_addr1  = '0;
        bus.req_wdata0 = '0;
        bus.req_wdata1 = '0;
        for (int a = 0; a < 65536; a++) begin
            pre_mem[a] = '0;
            wr_vld[a]  = 1'b0;
        end
        pre_mem[16'h0010] = 16'h1234;
        pre_mem[16'h0020] = 16'hA0A0;
        pre_mem[16'h0030] = 16'hB1B1;
        pre_mem[16'h0040] = 16'h4444;
        pre_mem[16'h0050] = 16'h5555;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Port 0 read of preloaded data: ack after edge 6
        do_txn("p0_read", 0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 7);

        // Port 1 write, then read it back
        do_txn("p1_write", 1, 1'b0, 16'h8000, 16'hBEEF, 16'h0000, 1'b0, 2);
        do_txn("p1_readback", 1, 1'b1, 16'h8000, 16'h0000, 16'hBEEF, 1'b0, 7);

        // Boundary addresses are ordinary
        do_txn("wr_ffff", 0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2);
        do_txn("wr_0000", 1, 1'b0, 16'h0000, 16'hA5A5, 16'h0000, 1'b0, 2);
        do_txn("rd_ffff", 1, 1'b1, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 7);
        do_txn("rd_0000", 0, 1'b1, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 7);

        // Dual continuous reads right after reset: grant order 0,1,0,1
        apply_reset();
        @(negedge clk);
        set_port(0, 1'b1, 16'h0020, 16'h0000);
        set_port(1, 1'b1, 16'h0030, 16'h0000);
        expect_txn(0, 1'b1, 16'h0020, 16'h0000, 16'hA0A0, 1'b0, 1'b1);
        expect_txn(1, 1'b1, 16'h0030, 16'h0000, 16'hB1B1, 1'b0, 1'b1);
        expect_txn(0, 1'b1, 16'h0020, 16'h0000, 16'hA0A0, 1'b0, 1'b1);
        expect_txn(1, 1'b1, 16'h0030, 16'h0000, 16'hB1B1, 1'b0, 1'b1);
        bus.req = 2'b11;
        rem0 = 2; rem1 = 2; n = 0;
        for (int i = 0; i < 300 && n < 4; i++) begin
            @(negedge clk);
            if (bus.ack[0] && rem0 > 0) begin
                rem0--; n++;
                if (rem0 == 0) bus.req[0] = 1'b0;
            end
            if (bus.ack[1] && rem1 > 0) begin
                rem1--; n++;
                if (rem1 == 0) bus.req[1] = 1'b0;
            end
        end
        bus.req = 2'b00;
        check("dual_done", 32'(n), 32'd4);

        // Timeout: mfc never comes, 15 cycles in WAIT, then ERRDATA with rsp_err
        no_mfc = 1'b1;
        do_txn("timeout", 0, 1'b1, 16'h0010, 16'h0000, 16'hFFFF, 1'b1, 17);
        no_mfc = 1'b0;
        repeat (8) @(negedge clk);
        do_txn("after_timeout", 1, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0, 7);

        // Async reset while in WAIT; the stray mfc that follows must be ignored
        @(negedge clk);
        expect_txn(0, 1'b1, 16'h0040, 16'h0000, 16'h4444, 1'b0, 1'b0);
        set_port(0, 1'b1, 16'h0040, 16'h0000);
        bus.req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        bus.req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.mem_mfc) seen = 1;
        end
        check("stray_mfc_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("stray_mfc_busy", 32'(bus.busy), 32'd0);
        check("stray_mfc_ack", 32'(bus.ack), 32'd0);
        do_txn("p1_after_reset", 1, 1'b1, 16'h0050, 16'h0000, 16'h5555, 1'b0, 7);

        // mfc forced high in IDLE with no request: nothing happens
        @(negedge clk);
        mfc_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_mfc_busy", 32'(bus.busy), 32'd0);
            check("idle_mfc_ack", 32'(bus.ack), 32'd0);
            check("idle_mfc_strobe", 32'(bus.mem_strobe), 32'd0);
        end
        mfc_force = 1'b0;

        // Every expected strobe and ack must have been consumed
        repeat (4) @(negedge clk);
        check("pending_acks", 32'(ack_q.size()), 32'd0);
        check("pending_strobes", 32'(strobe_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slowmem_arbiter.md
Name: slowmem_arbiter

Overview:
Two-port memory-side initiator that sits between the per-thread cache refill paths and the shared slowmem. It accepts read and write requests on a req/ack handshake and arbitrates round-robin between the ports. It drives the slowmem strobe/rnotw/addr/wdata protocol, waits for mfc on reads, and returns data with a one-cycle ack. A read timeout guarantees forward progress if mfc never arrives.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 15, max cycles in WAIT before a read is aborted; legal range 1..255
ERRDATA, 16'hFFFF, rsp_rdata value returned on timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  2  per-port request; held high with fields stable until the matching ack
req_rnotw  input  2  per-port direction: 1=read, 0=write
req_addr0  input  AW  port 0 address
req_addr1  input  AW  port 1 address
req_wdata0  input  DW  port 0 write data
req_wdata1  input  DW  port 1 write data
ack  output  2  one-cycle completion pulse, one-hot, to the granted port
rsp_rdata  output  DW  read data; valid only while ack is high
rsp_err  output  1  high with ack when a read timed out
busy  output  1  high in every state except IDLE
mem_strobe  output  1  slowmem strobe
mem_rnotw  output  1  slowmem direction
mem_addr  output  AW  slowmem address
mem_wdata  output  DW  slowmem write data
mem_mfc  input  1  slowmem fetch-complete pulse
mem_rdata  input  DW  slowmem read data, valid with mem_mfc

Behaviour:
- All outputs are registered.
- Reset values: ack=0, rsp_rdata=0, rsp_err=0, busy=0, mem_strobe=0, mem_rnotw=1, mem_addr=0, mem_wdata=0, state=IDLE, last_grant=1, wait counter=0.
- Reset is asynchronous. Asserting it in any state aborts the operation immediately with no ack. An mfc that belongs to an aborted read is ignored.
- States: IDLE, STROBE, WAIT, ACK.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If one req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On a grant: latch the port's rnotw, addr and wdata into the mem_* registers, set mem_strobe=1, update last_grant, go to STROBE.
- STROBE: lasts exactly one cycle. Clear mem_strobe. If the op is a write, go to ACK (slowmem commits the write on this edge). If it is a read, clear the counter and go to WAIT.
- WAIT:
  - If mem_mfc is high, capture mem_rdata into rsp_rdata, set rsp_err=0, go to ACK.
  - Otherwise, if counter==TIMEOUT-1, set rsp_rdata=ERRDATA and rsp_err=1, go to ACK.
  - Otherwise increment the counter (8 bits).
  - When mfc and timeout coincide, mfc wins.
- ACK: ack[grant]=1 for exactly this cycle. rsp_rdata and rsp_err hold for this cycle. Next state is IDLE, and ack, rsp_err and rsp_rdata clear.
- The requester drops req on the edge at which it samples ack. Because ACK always returns to IDLE first, a req still high during the ACK cycle is not regranted.
- Latency, counting edge 0 as the edge at which IDLE samples req:
  - Write: ack is high after edge 1.
  - Read with slowmem MEMDELAY=4: slowmem samples strobe at edge 1, mfc is high after edge 5, ack and data are high after edge 6.
- Only one transaction is outstanding at a time. mem_addr, mem_wdata and mem_rnotw hold stable from grant until IDLE is re-entered.
- mem_mfc is ignored in IDLE, STROBE and ACK.
- Address and data pass through unmodified, with no arithmetic and no wrap. Addresses 16'hFFFF and 0 are ordinary.
- Round-robin: after reset, port 0 wins a tie. Under continuous dual requests, grants strictly alternate 0,1,0,1.

Test Plan:
- Preload slowmem m[16'h0010]=16'h1234; port 0 reads 16'h0010 -> mem_strobe high exactly 1 cycle with mem_addr=16'h0010 and mem_rnotw=1; ack=2'b01 after edge 6; rsp_rdata=16'h1234; rsp_err=0; busy low the following cycle.
- Port 1 writes 16'hBEEF to 16'h8000, then reads 16'h8000 -> write ack=2'b10 after edge 1 with no mfc involved; read returns 16'hBEEF.
- Both ports request reads right after reset, held continuously for 4 transactions -> grant order 0,1,0,1; no cycle with ack=2'b11; the ACK to IDLE gap is present between transactions.
- Memory model never raises mfc, TIMEOUT=15, port 0 reads -> ack=2'b01 after 15 cycles in WAIT; rsp_err=1; rsp_rdata=16'hFFFF; next request is served normally.
- reset pulsed while in WAIT; slowmem's mfc then arrives -> all outputs return to reset values asynchronously; no ack; stray mfc ignored; subsequent port 1 read completes with correct data.
- mfc forced high in IDLE with no req -> no state change; ack stays 0; busy stays 0.
